// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commits the prioritised MEM1 exception as CP0 strobes, a held IF redirect and a drain window.
// Exception and entry-select encodings below are shared with the MEM1 prioritiser.
module exc_commit_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        MEM_Valid,
    input  logic [4:0]  MEM_ExcType,
    input  logic [1:0]  EX_Entry_Sel,
    input  logic [31:0] Exception_Vector,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_IsInDelaySlot,
    input  logic [31:0] MEM_DataVAddr,
    input  logic [31:0] CP0_EPC,
    input  logic        CP0_Status_EXL,
    input  logic        IF_RedirectReady,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic        Commit_Busy,
    output logic        CP0_ExcWr,
    output logic [31:0] CP0_ExcEPC,
    output logic [4:0]  CP0_ExcCode,
    output logic        CP0_ExcBD,
    output logic        CP0_BadVAddrWr,
    output logic [31:0] CP0_BadVAddr,
    output logic        CP0_EntryHiWr,
    output logic        CP0_SetEXL,
    output logic        CP0_ClrEXL
);
    localparam logic [4:0] EX_NONE = 5'd0, EX_INT = 5'd1, EX_TLB_MOD = 5'd2,
        EX_TLB_REFILL_IF = 5'd3, EX_TLB_INVALID_IF = 5'd4, EX_TLB_REFILL_RD = 5'd5,
        EX_TLB_INVALID_RD = 5'd6, EX_TLB_REFILL_WR = 5'd7, EX_TLB_INVALID_WR = 5'd8,
        EX_ADDR_IF = 5'd9, EX_ADDR_RD = 5'd10, EX_ADDR_WR = 5'd11, EX_SYS = 5'd12,
        EX_BP = 5'd13, EX_RI = 5'd14, EX_CPU = 5'd15, EX_OV = 5'd16, EX_TR = 5'd17;
    localparam logic [1:0] IS_NONE = 2'd0, IS_EXCEPTION = 2'd1, IS_ERET = 2'd2, IS_REFETCH = 2'd3;

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        accept, take_exc, bad, tlb, if_side;
    logic [4:0]  code;

    assign accept   = (state == IDLE) && MEM_Valid && (EX_Entry_Sel != IS_NONE);
    assign take_exc = accept && (EX_Entry_Sel == IS_EXCEPTION);

    // bad: writes BadVAddr; tlb: also EntryHi.VPN2; if_side: faulting address is the PC
    always_comb begin
        code    = 5'h00;
        bad     = 1'b0;
        tlb     = 1'b0;
        if_side = 1'b0;
        case (MEM_ExcType)
            EX_NONE, EX_INT: code = 5'h00;
            EX_TLB_MOD: begin code = 5'h01; bad = 1'b1; tlb = 1'b1; end
            EX_TLB_REFILL_IF, EX_TLB_INVALID_IF: begin code = 5'h02; bad = 1'b1; tlb = 1'b1; if_side = 1'b1; end
            EX_TLB_REFILL_RD, EX_TLB_INVALID_RD: begin code = 5'h02; bad = 1'b1; tlb = 1'b1; end
            EX_TLB_REFILL_WR, EX_TLB_INVALID_WR: begin code = 5'h03; bad = 1'b1; tlb = 1'b1; end
            EX_ADDR_IF: begin code = 5'h04; bad = 1'b1; if_side = 1'b1; end
            EX_ADDR_RD: begin code = 5'h04; bad = 1'b1; end
            EX_ADDR_WR: begin code = 5'h05; bad = 1'b1; end
            EX_SYS: code = 5'h08;
            EX_BP:  code = 5'h09;
            EX_RI:  code = 5'h0a;
            EX_CPU: code = 5'h0b;
            EX_OV:  code = 5'h0c;
            EX_TR:  code = 5'h0d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            Redirect_Valid <= 1'b0;
            Redirect_PC    <= 32'h0;
            Commit_Busy    <= 1'b0;
            CP0_ExcWr      <= 1'b0;
            CP0_ExcEPC     <= 32'h0;
            CP0_ExcCode    <= 5'h0;
            CP0_ExcBD      <= 1'b0;
            CP0_BadVAddrWr <= 1'b0;
            CP0_BadVAddr   <= 32'h0;
            CP0_EntryHiWr  <= 1'b0;
            CP0_SetEXL     <= 1'b0;
            CP0_ClrEXL     <= 1'b0;
        end else begin
            CP0_ExcWr      <= take_exc;
            CP0_SetEXL     <= take_exc;
            CP0_BadVAddrWr <= take_exc && bad;
            CP0_EntryHiWr  <= take_exc && tlb;
            CP0_ClrEXL     <= accept && (EX_Entry_Sel == IS_ERET);
            // With EXL already set, EPC is rewritten with its own value and BD with the last committed one
            if (take_exc) begin
                CP0_ExcCode <= code;
                CP0_ExcEPC  <= CP0_Status_EXL ? CP0_EPC : (MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC);
                CP0_ExcBD   <= CP0_Status_EXL ? CP0_ExcBD : MEM_IsInDelaySlot;
                if (bad)
                    CP0_BadVAddr <= if_side ? MEM_PC : MEM_DataVAddr;
            end
            case (state)
                IDLE: if (accept) begin
                    state          <= REDIRECT;
                    Redirect_Valid <= 1'b1;
                    Commit_Busy    <= 1'b1;
                    Redirect_PC    <= (EX_Entry_Sel == IS_EXCEPTION) ? Exception_Vector :
                                      (EX_Entry_Sel == IS_REFETCH)   ? MEM_PC : CP0_EPC;
                end
                REDIRECT: if (IF_RedirectReady) begin
                    state          <= DRAIN;
                    cnt            <= 4'(DRAIN_CYCLES - 1);
                    Redirect_Valid <= 1'b0;
                end
                DRAIN: if (cnt == 4'd0) begin
                    state       <= IDLE;
                    Commit_Busy <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: scenario tasks with a queue of expected commits popped one cycle after acceptance.
module tb_exc_commit_ctrl;
    localparam logic [4:0] EX_INT = 5'd1, EX_TLB_INVALID_IF = 5'd4, EX_TLB_REFILL_WR = 5'd7,
        EX_ADDR_RD = 5'd10, EX_SYS = 5'd12, EX_OV = 5'd16;
    localparam logic [1:0] IS_EXCEPTION = 2'd1, IS_ERET = 2'd2, IS_REFETCH = 2'd3;
    localparam int DRAIN = 2;

    typedef struct packed {
        logic        excwr;
        logic [31:0] epc;
        logic [4:0]  code;
        logic        bd;
        logic        badwr;
        logic [31:0] badv;
        logic        entryhi;
        logic        setexl;
        logic        clrexl;
        logic        rvalid;
        logic [31:0] rpc;
    } commit_t;

    logic        clk = 1'b0, resetn;
    logic        MEM_Valid, MEM_IsInDelaySlot, CP0_Status_EXL, IF_RedirectReady;
    logic [4:0]  MEM_ExcType;
    logic [1:0]  EX_Entry_Sel;
    logic [31:0] Exception_Vector, MEM_PC, MEM_DataVAddr, CP0_EPC;
    logic        Redirect_Valid, Commit_Busy, CP0_ExcWr, CP0_ExcBD, CP0_BadVAddrWr;
    logic        CP0_EntryHiWr, CP0_SetEXL, CP0_ClrEXL;
    logic [31:0] Redirect_PC, CP0_ExcEPC, CP0_BadVAddr;
    logic [4:0]  CP0_ExcCode;

    commit_t exp_q[$];
    commit_t got, want;
    int      checks = 0, passed = 0;
    logic    last_bd = 1'b0;
    bit      to;

    exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .resetn(resetn), .MEM_Valid(MEM_Valid), .MEM_ExcType(MEM_ExcType),
        .EX_Entry_Sel(EX_Entry_Sel), .Exception_Vector(Exception_Vector), .MEM_PC(MEM_PC),
        .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .MEM_DataVAddr(MEM_DataVAddr), .CP0_EPC(CP0_EPC),
        .CP0_Status_EXL(CP0_Status_EXL), .IF_RedirectReady(IF_RedirectReady),
        .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC), .Commit_Busy(Commit_Busy),
        .CP0_ExcWr(CP0_ExcWr), .CP0_ExcEPC(CP0_ExcEPC), .CP0_ExcCode(CP0_ExcCode),
        .CP0_ExcBD(CP0_ExcBD), .CP0_BadVAddrWr(CP0_BadVAddrWr), .CP0_BadVAddr(CP0_BadVAddr),
        .CP0_EntryHiWr(CP0_EntryHiWr), .CP0_SetEXL(CP0_SetEXL), .CP0_ClrEXL(CP0_ClrEXL)
    );

    always #5 clk = ~clk;

    wire [108:0] all_out = {Redirect_Valid, Redirect_PC, Commit_Busy, CP0_ExcWr, CP0_ExcEPC,
        CP0_ExcCode, CP0_ExcBD, CP0_BadVAddrWr, CP0_BadVAddr, CP0_EntryHiWr, CP0_SetEXL, CP0_ClrEXL};
    wire [4:0] strobes = {CP0_ExcWr, CP0_BadVAddrWr, CP0_EntryHiWr, CP0_SetEXL, CP0_ClrEXL};

    // value fields are only meaningful alongside their write strobe
    function automatic commit_t observe();
        commit_t o;
        o.excwr   = CP0_ExcWr;
        o.epc     = CP0_ExcWr ? CP0_ExcEPC : 32'h0;
        o.code    = CP0_ExcWr ? CP0_ExcCode : 5'h0;
        o.bd      = CP0_ExcWr ? CP0_ExcBD : 1'b0;
        o.badwr   = CP0_BadVAddrWr;
        o.badv    = CP0_BadVAddrWr ? CP0_BadVAddr : 32'h0;
        o.entryhi = CP0_EntryHiWr;
        o.setexl  = CP0_SetEXL;
        o.clrexl  = CP0_ClrEXL;
        o.rvalid  = Redirect_Valid;
        o.rpc     = Redirect_PC;
        return o;
    endfunction

    function automatic commit_t mk(input logic w, input logic [31:0] epc, input logic [4:0] code,
                                   input logic bd, input logic bw, input logic [31:0] bv,
                                   input logic eh, input logic se, input logic ce, input logic [31:0] rpc);
        return '{w, epc, code, bd, bw, bv, eh, se, ce, 1'b1, rpc};
    endfunction

    task automatic present(input logic [1:0] sel, input logic [4:0] typ, input logic [31:0] pc,
                           input logic bd, input logic [31:0] dva, input logic [31:0] vec,
                           input logic [31:0] epc, input logic exl);
        MEM_Valid = 1'b1; EX_Entry_Sel = sel; MEM_ExcType = typ; MEM_PC = pc;
        MEM_IsInDelaySlot = bd; MEM_DataVAddr = dva; Exception_Vector = vec;
        CP0_EPC = epc; CP0_Status_EXL = exl;
        @(negedge clk);
        MEM_Valid = 1'b0; EX_Entry_Sel = 2'd0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (Commit_Busy && n < 50) begin @(negedge clk); n++; end
        timed_out = Commit_Busy;
    endtask

    task automatic test_reset();
        resetn = 1'b0; MEM_Valid = 1'b0; EX_Entry_Sel = 2'd0; MEM_ExcType = 5'd0; MEM_PC = 32'h0;
        MEM_IsInDelaySlot = 1'b0; MEM_DataVAddr = 32'h0; Exception_Vector = 32'h0; CP0_EPC = 32'h0;
        CP0_Status_EXL = 1'b0; IF_RedirectReady = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== 109'h0) $display("FAIL reset outputs got=%h want=0", all_out); else passed++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_syscall();
        int n = 1;
        exp_q.push_back(mk(1, 32'h8000_1000, 5'h08, 0, 0, 0, 0, 1, 0, 32'h8000_0180));
        last_bd = 1'b0;
        present(IS_EXCEPTION, EX_SYS, 32'h8000_1000, 0, 32'h0, 32'h8000_0180, 32'h0, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL syscall commit got=%h want=%h", got, want); else passed++;
        @(negedge clk);
        checks++;
        if ({strobes, Redirect_Valid, Commit_Busy} !== 7'b0000001)
            $display("FAIL syscall one-shot got=%b want=0000001", {strobes, Redirect_Valid, Commit_Busy});
        else passed++;
        while (Commit_Busy && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 1 + DRAIN) $display("FAIL syscall busy_cycles got=%0d want=%0d", n, 1 + DRAIN); else passed++;
    endtask

    task automatic test_adel_delay_slot();
        exp_q.push_back(mk(1, 32'hBFC0_0100, 5'h04, 1, 1, 32'h3, 0, 1, 0, 32'h8000_0180));
        last_bd = 1'b1;
        present(IS_EXCEPTION, EX_ADDR_RD, 32'hBFC0_0104, 1, 32'h3, 32'h8000_0180, 32'h0, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL adel commit got=%h want=%h", got, want); else passed++;
        wait_idle(to); checks++;
        if (to) $display("FAIL adel idle_timeout got=busy want=idle"); else passed++;
    endtask

    task automatic test_tlb_store_stall();
        IF_RedirectReady = 1'b0;
        exp_q.push_back(mk(1, 32'h8000_4000, 5'h03, 0, 1, 32'h1234_5678, 1, 1, 0, 32'h8000_0000));
        last_bd = 1'b0;
        present(IS_EXCEPTION, EX_TLB_REFILL_WR, 32'h8000_4000, 0, 32'h1234_5678, 32'h8000_0000, 32'h0, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL tlbs commit got=%h want=%h", got, want); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); checks++;
            if ({Redirect_Valid, Redirect_PC, Commit_Busy, strobes} !== {1'b1, 32'h8000_0000, 1'b1, 5'b0})
                $display("FAIL tlbs hold[%0d] got=%b/%h want=1/80000000", i, Redirect_Valid, Redirect_PC);
            else passed++;
        end
        IF_RedirectReady = 1'b1;
        @(negedge clk); checks++;
        if ({Redirect_Valid, Commit_Busy} !== 2'b01)
            $display("FAIL tlbs drop got=%b want=01", {Redirect_Valid, Commit_Busy});
        else passed++;
        wait_idle(to); checks++;
        if (to) $display("FAIL tlbs idle_timeout got=busy want=idle"); else passed++;
    endtask

    task automatic test_eret_refetch();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_2000));
        present(IS_ERET, 5'd0, 32'h8000_7000, 0, 32'h0, 32'h8000_0180, 32'h8000_2000, 1);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL eret commit got=%h want=%h", got, want); else passed++;
        wait_idle(to);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_3000));
        present(IS_REFETCH, 5'd0, 32'h8000_3000, 0, 32'h0, 32'h8000_0180, 32'h8000_2000, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL refetch commit got=%h want=%h", got, want); else passed++;
        wait_idle(to); checks++;
        if (to) $display("FAIL refetch idle_timeout got=busy want=idle"); else passed++;
    endtask

    task automatic test_ov_exl_and_drain();
        exp_q.push_back(mk(1, 32'h8000_2000, 5'h0c, last_bd, 0, 0, 0, 1, 0, 32'h8000_0180));
        present(IS_EXCEPTION, EX_OV, 32'h8000_5000, 1, 32'h0, 32'h8000_0180, 32'h8000_2000, 1);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL ov_exl commit got=%h want=%h", got, want); else passed++;
        MEM_Valid = 1'b1; EX_Entry_Sel = IS_EXCEPTION; MEM_ExcType = EX_SYS; CP0_Status_EXL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin MEM_Valid = 1'b0; EX_Entry_Sel = 2'd0; end
            checks++;
            if ({strobes, Redirect_Valid} !== 6'b0)
                $display("FAIL drain ignore[%0d] got=%b want=000000", i, {strobes, Redirect_Valid});
            else passed++;
        end
        checks++;
        if (Commit_Busy !== 1'b0) $display("FAIL drain end got=%b want=0", Commit_Busy); else passed++;
    endtask

    task automatic test_back_to_back_wrap();
        exp_q.push_back(mk(1, 32'hFFFF_FFFC, 5'h00, 1, 0, 0, 0, 1, 0, 32'h8000_0180));
        present(IS_EXCEPTION, EX_INT, 32'h0, 1, 32'h0, 32'h8000_0180, 32'h0, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL int_wrap commit got=%h want=%h", got, want); else passed++;
        wait_idle(to);
        exp_q.push_back(mk(1, 32'h0040_0000, 5'h02, 0, 1, 32'h0040_0000, 1, 1, 0, 32'h8000_0180));
        present(IS_EXCEPTION, EX_TLB_INVALID_IF, 32'h0040_0000, 0, 32'hDEAD_BEEF, 32'h8000_0180, 32'h0, 0);
        got = observe(); want = exp_q.pop_front(); checks++;
        if (got !== want) $display("FAIL tlb_if commit got=%h want=%h", got, want); else passed++;
        wait_idle(to); checks++;
        if (to) $display("FAIL tlb_if idle_timeout got=busy want=idle"); else passed++;
    endtask

    task automatic test_reset_mid_redirect();
        IF_RedirectReady = 1'b0;
        present(IS_EXCEPTION, EX_SYS, 32'h8000_6000, 0, 32'h0, 32'h8000_0180, 32'h0, 0);
        checks++;
        if (Redirect_Valid !== 1'b1) $display("FAIL rst_mid pending got=%b want=1", Redirect_Valid); else passed++;
        resetn = 1'b0;
        @(negedge clk); checks++;
        if (all_out !== 109'h0) $display("FAIL rst_mid cleared got=%h want=0", all_out); else passed++;
        resetn = 1'b1; IF_RedirectReady = 1'b1;
        @(negedge clk); checks++;
        if ({strobes, Redirect_Valid, Commit_Busy} !== 7'b0)
            $display("FAIL rst_mid discarded got=%b want=0000000", {strobes, Redirect_Valid, Commit_Busy});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_adel_delay_slot();
        test_tlb_store_stall();
        test_eret_refetch();
        test_ov_exl_and_drain();
        test_back_to_back_wrap();
        test_reset_mid_redirect();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
